// File: rtl/gpio_loopback_checker.sv
// Loopback checker for the free-running GPIO test counter: synchronises the pins,
// locks onto the +1-per-clock pattern, counts mismatches and reports per-bit stuck-at flags.
module gpio_loopback_checker #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int MISS_LIMIT  = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             pll_LOCKED,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic             clear,
  output logic             locked,
  output logic             pass,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_bad,
  output logic [WIDTH-1:0] stuck_hi,
  output logic [WIDTH-1:0] stuck_lo
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  s;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [WIDTH-1:0]  seen0_q, seen0_d;
  logic [WIDTH-1:0]  seen1_q, seen1_d;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic              span_q, span_d;
  logic [WIDTH-1:0]  prev_inc;

  logic              locked_d, pass_d, err_pulse_d;
  logic [ERR_W-1:0]  err_count_d;
  logic [WIDTH-1:0]  last_bad_d, stuck_hi_d, stuck_lo_d;

  always_ff @(posedge clk or negedge pll_LOCKED) begin
    if (!pll_LOCKED) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign prev_inc = prev_q + WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q + WIDTH'(1);
    run_d       = run_q;
    miss_d      = miss_q;
    seen0_d     = seen0_q | ~s;
    seen1_d     = seen1_q | s;
    sample_d    = sample_q + WIDTH'(1);
    span_d      = span_q | (sample_q == '1);
    err_pulse_d = 1'b0;
    err_count_d = err_count;
    last_bad_d  = last_bad;

    case (state_q)
      ST_ACQUIRE: begin
        if (s == prev_inc) begin
          if (run_q == RUN_LAST) begin
            state_d = ST_LOCKED;
            exp_d   = s + WIDTH'(1);
            run_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d = '0;
        end
      end
      ST_LOCKED: begin
        // Predictor keeps running through errors so a lone glitch costs one count
        if (s != exp_q) begin
          err_pulse_d = 1'b1;
          last_bad_d  = s;
          if (err_count != '1) err_count_d = err_count + ERR_W'(1);
          if (miss_q == MISS_LAST) begin
            state_d = ST_ACQUIRE;
            run_d   = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end else begin
          miss_d = '0;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase

    if (clear) begin
      state_d     = ST_ACQUIRE;
      run_d       = '0;
      miss_d      = '0;
      seen0_d     = '0;
      seen1_d     = '0;
      sample_d    = '0;
      span_d      = 1'b0;
      err_pulse_d = 1'b0;
      err_count_d = '0;
      last_bad_d  = '0;
    end

    locked_d   = (state_d == ST_LOCKED);
    pass_d     = locked_d && span_d && (err_count_d == '0);
    stuck_hi_d = span_d ? ~seen0_d : '0;
    stuck_lo_d = span_d ? ~seen1_d : '0;
  end

  always_ff @(posedge clk or negedge pll_LOCKED) begin
    if (!pll_LOCKED) begin
      state_q   <= ST_ACQUIRE;
      prev_q    <= '1;
      exp_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      seen0_q   <= '0;
      seen1_q   <= '0;
      sample_q  <= '0;
      span_q    <= 1'b0;
      locked    <= 1'b0;
      pass      <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      last_bad  <= '0;
      stuck_hi  <= '0;
      stuck_lo  <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= s;
      exp_q     <= exp_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      seen0_q   <= seen0_d;
      seen1_q   <= seen1_d;
      sample_q  <= sample_d;
      span_q    <= span_d;
      locked    <= locked_d;
      pass      <= pass_d;
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
      last_bad  <= last_bad_d;
      stuck_hi  <= stuck_hi_d;
      stuck_lo  <= stuck_lo_d;
    end
  end

endmodule

// File: tb/tb_gpio_loopback_checker.sv
// Directed bench for gpio_loopback_checker: drives the looped-back counter with glitches,
// stuck bits, clear and reset, and compares outputs against hand-derived values.
module tb_gpio_loopback_checker;

  logic        clk = 1'b0;
  logic        pll_LOCKED;
  logic [7:0]  gpio_in;
  logic        clear;
  logic        locked, pass, err_pulse;
  logic [15:0] err_count;
  logic [7:0]  last_bad, stuck_hi, stuck_lo;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  cnt;
  logic        hold_zero;
  logic [7:0]  or_mask;
  int          pulses;
  int          drops;
  logic        was_locked;

  gpio_loopback_checker dut (
    .clk       (clk),
    .pll_LOCKED(pll_LOCKED),
    .gpio_in   (gpio_in),
    .clear     (clear),
    .locked    (locked),
    .pass      (pass),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .last_bad  (last_bad),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One call = n clock edges; the source counter advances just after each edge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cnt     = cnt + 8'd1;
      gpio_in = hold_zero ? 8'h00 : (cnt | or_mask);
    end
  endtask

  task automatic advanceTo(input logic [7:0] target);
    for (int i = 0; i < 256 && cnt != target; i++) applyStimulus(1);
  endtask

  task automatic waitLock(input string tag);
    for (int i = 0; i < 20 && !locked; i++) applyStimulus(1);
    checkOutput(tag, locked, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pll_LOCKED = 1'b0;
    clear      = 1'b0;
    hold_zero  = 1'b0;
    or_mask    = 8'h00;
    cnt        = 8'hFF;
    gpio_in    = 8'hFF;
    #2;
    checkOutput("reset_locked",    locked,    0);
    checkOutput("reset_pass",      pass,      0);
    checkOutput("reset_err_pulse", err_pulse, 0);
    checkOutput("reset_err_count", err_count, 0);
    checkOutput("reset_stuck_hi",  stuck_hi,  0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    pll_LOCKED = 1'b1;

    // Clean counter from 0xFF: lock on the 7th edge, pass once the 256-sample span completes
    applyStimulus(6);
    checkOutput("lock_not_yet", locked, 0);
    applyStimulus(1);
    checkOutput("lock_acquired", locked, 1);
    applyStimulus(248);
    checkOutput("pass_before_span", pass, 0);
    applyStimulus(1);
    checkOutput("pass_after_span",  pass,      1);
    checkOutput("clean_err_count",  err_count, 0);
    checkOutput("clean_stuck_hi",   stuck_hi,  0);
    checkOutput("clean_stuck_lo",   stuck_lo,  0);

    // Isolated glitch: 0x40 where 0x42 is due
    advanceTo(8'h42);
    gpio_in = 8'h40;
    applyStimulus(2);
    checkOutput("glitch_no_early_pulse", err_pulse, 0);
    applyStimulus(1);
    checkOutput("glitch_pulse",     err_pulse, 1);
    checkOutput("glitch_err_count", err_count, 1);
    checkOutput("glitch_last_bad",  last_bad,  8'h40);
    checkOutput("glitch_locked",    locked,    1);
    checkOutput("glitch_pass",      pass,      0);
    applyStimulus(1);
    checkOutput("glitch_next_ok",    err_pulse, 0);
    checkOutput("glitch_count_hold", err_count, 1);

    // Clear lands on the same edge as a bad sample
    gpio_in = cnt - 8'd2;
    applyStimulus(2);
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    checkOutput("clear_err_pulse", err_pulse, 0);
    checkOutput("clear_err_count", err_count, 0);
    checkOutput("clear_locked",    locked,    0);
    checkOutput("clear_last_bad",  last_bad,  0);
    applyStimulus(4);
    checkOutput("clear_relock_wait", locked, 0);
    applyStimulus(1);
    checkOutput("clear_relock", locked, 1);

    // Bus stuck at zero while locked
    hold_zero = 1'b1;
    gpio_in   = 8'h00;
    pulses    = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      pulses += int'(err_pulse);
    end
    checkOutput("zero_pulses",    pulses,    4);
    checkOutput("zero_err_count", err_count, 4);
    checkOutput("zero_unlocked",  locked,    0);
    applyStimulus(10);
    checkOutput("zero_count_static", err_count, 4);
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    applyStimulus(255);
    checkOutput("zero_stuck_lo_pre_span", stuck_lo, 0);
    applyStimulus(1);
    checkOutput("zero_stuck_lo", stuck_lo, 8'hFF);
    checkOutput("zero_stuck_hi", stuck_hi, 8'h00);
    checkOutput("zero_pass",     pass,     0);

    // Bit 3 stuck high over a full span
    hold_zero = 1'b0;
    or_mask   = 8'h08;
    gpio_in   = cnt | or_mask;
    applyStimulus(4);
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    drops = 0;
    for (int i = 0; i < 256; i++) begin
      was_locked = locked;
      applyStimulus(1);
      if (was_locked && !locked) drops++;
    end
    checkOutput("bit3_stuck_hi",   stuck_hi, 8'h08);
    checkOutput("bit3_stuck_lo",   stuck_lo, 8'h00);
    checkOutput("bit3_errors_seen", err_count != 16'h0000, 1);
    checkOutput("bit3_lock_drops",  drops > 0, 1);
    checkOutput("bit3_pass",        pass, 0);

    // Saturated error counter, then asynchronous reset between edges
    or_mask = 8'h00;
    gpio_in = cnt;
    applyStimulus(8);
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    waitLock("sat_relock");
    gpio_in = cnt - 8'd2;
    force dut.err_count = 16'hFFFF;
    applyStimulus(1);
    release dut.err_count;
    applyStimulus(2);
    checkOutput("sat_pulse", err_pulse, 1);
    checkOutput("sat_count", err_count, 16'hFFFF);
    applyStimulus(1);
    checkOutput("sat_count_hold", err_count, 16'hFFFF);
    checkOutput("sat_pulse_end",  err_pulse, 0);
    #2;
    pll_LOCKED = 1'b0;
    #1;
    checkOutput("async_locked",    locked,    0);
    checkOutput("async_pass",      pass,      0);
    checkOutput("async_err_pulse", err_pulse, 0);
    checkOutput("async_err_count", err_count, 0);
    checkOutput("async_last_bad",  last_bad,  0);
    checkOutput("async_stuck_hi",  stuck_hi,  0);
    checkOutput("async_stuck_lo",  stuck_lo,  0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
